adc_peak_capture: RTL and testbench

ADC_PEAK_CAPTURE -- requirements
Module: adc_peak_capture

---
 rtl/adc_peak_capture.sv | 158 +++++++++++++++
 tb/tb_adc_peak_capture.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_peak_capture.sv
// ADC peak capture for a pulse-height analyser.
// The comparator flag is synchronised and the ADC stream is delayed by the
// same two cycles, so every sample lines up with the synchronised flag.
// Pulses of MIN_WIDTH..MAX_WIDTH cycles produce one peak event on a
// valid/ready output. Too-short, too-long, overflow and pile-up events raise
// a one-cycle reject pulse instead.
// Optional feature: define MCA_REJECT_CNT_EN to get a saturating 16-bit
// reject counter on rej_cnt. Without it, rej_cnt is tied to zero.
module adc_peak_capture #(
    parameter int ADC_W     = 10,
    parameter int MIN_WIDTH = 2,
    parameter int MAX_WIDTH = 64,
    parameter int DEAD_TIME = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             comparator,
    input  logic [ADC_W-1:0] adc_in,
    output logic [ADC_W-1:0] peak_out,
    output logic             peak_valid,
    input  logic             peak_ready,
    output logic             busy,
    output logic             reject,
    output logic [15:0]      rej_cnt
);

    localparam int WIDTH_W = $clog2(MAX_WIDTH + 1);
    localparam int DEAD_W  = $clog2(DEAD_TIME + 1);

    localparam logic [WIDTH_W-1:0] WIDTH_MAX = WIDTH_W'(MAX_WIDTH);
    localparam logic [WIDTH_W-1:0] WIDTH_MIN = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0] WIDTH_ONE = WIDTH_W'(1);
    localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'(DEAD_TIME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t             state;
    logic               comp_meta;
    logic               comp_s;
    logic               comp_prev;
    logic [ADC_W-1:0]   adc_d1;
    logic [ADC_W-1:0]   adc_d;
    logic [ADC_W-1:0]   peak;
    logic [WIDTH_W-1:0] width;
    logic [DEAD_W-1:0]  dead_cnt;
    logic               slot_free;
    logic               comp_rise;

    // The output slot can take a new event if it is empty or is being consumed now.
    assign slot_free = !peak_valid || peak_ready;
    assign comp_rise = comp_s && !comp_prev;

    // Synchronise the comparator and delay the ADC samples to stay aligned with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_meta <= 1'b0;
            comp_s    <= 1'b0;
            comp_prev <= 1'b0;
            adc_d1    <= '0;
            adc_d     <= '0;
        end else begin
            comp_meta <= comparator;
            comp_s    <= comp_meta;
            comp_prev <= comp_s;
            adc_d1    <= adc_in;
            adc_d     <= adc_d1;
        end
    end

    // Pulse qualification FSM with registered event, busy and reject outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            peak       <= '0;
            width      <= '0;
            dead_cnt   <= '0;
            peak_out   <= '0;
            peak_valid <= 1'b0;
            busy       <= 1'b0;
            reject     <= 1'b0;
        end else begin
            reject <= 1'b0;
            if (peak_valid && peak_ready) begin
                peak_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (comp_s) begin
                        state <= PULSE;
                        busy  <= 1'b1;
                        peak  <= adc_d;
                        width <= WIDTH_ONE;
                    end
                end
                PULSE: begin
                    if (comp_s) begin
                        if (width < WIDTH_MAX) begin
                            width <= width + 1'b1;
                            if (adc_d > peak) begin
                                peak <= adc_d;
                            end
                        end else begin
                            reject   <= 1'b1;
                            state    <= DEAD;
                            dead_cnt <= '0;
                        end
                    end else begin
                        state    <= DEAD;
                        dead_cnt <= '0;
                        if (width < WIDTH_MIN) begin
                            reject <= 1'b1;
                        end else if (slot_free) begin
                            peak_out   <= peak;
                            peak_valid <= 1'b1;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                DEAD: begin
                    if (comp_rise) begin
                        reject <= 1'b1;
                    end
                    if (dead_cnt == DEAD_LAST) begin
                        if (!comp_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MCA_REJECT_CNT_EN
    // Count reject pulses, holding at full scale instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_cnt <= 16'd0;
        end else if (reject && (rej_cnt != 16'hFFFF)) begin
            rej_cnt <= rej_cnt + 16'd1;
        end
    end
`else
    assign rej_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_adc_peak_capture.sv
// Testbench for adc_peak_capture: directed vector table, hand-written corner
// sequences, then randomized pulses against a behavioural reference model.
module tb_adc_peak_capture;

    localparam int ADC_W  = 10;
    localparam int MIN_W  = 2;
    localparam int MAX_W  = 64;
    localparam int DEAD_T = 4;
    localparam int NOISE  = (1 << ADC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             comparator = 1'b0;
    logic [ADC_W-1:0] adc_in = '0;
    logic             peak_ready = 1'b0;
    logic [ADC_W-1:0] peak_out;
    logic             peak_valid;
    logic             busy;
    logic             reject;
    logic [15:0]      rej_cnt;

    int errors = 0;
    int checks = 0;
    int ev_cnt;
    int rej_obs;
    int last_peak;
    int exp_rej_total = 0;

    always #5 clk = ~clk;

    adc_peak_capture #(
        .ADC_W(ADC_W), .MIN_WIDTH(MIN_W), .MAX_WIDTH(MAX_W), .DEAD_TIME(DEAD_T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .comparator(comparator), .adc_in(adc_in),
        .peak_out(peak_out), .peak_valid(peak_valid), .peak_ready(peak_ready),
        .busy(busy), .reject(reject), .rej_cnt(rej_cnt)
    );

    typedef struct {
        int len;
        int amp;
        int exp_events;
        int exp_peak;
        int exp_rej;
    } vec_t;

    vec_t vecs[7];

    function automatic int expCnt(input int n);
`ifdef MCA_REJECT_CNT_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (peak_valid && peak_ready) begin
            ev_cnt++;
            last_peak = int'(peak_out);
        end
        if (reject) rej_obs++;
    endtask

    task automatic applyStimulus(input logic c, input int a);
        comparator = c;
        adc_in     = ADC_W'(a);
        tick();
    endtask

    task automatic clearObs();
        ev_cnt    = 0;
        rej_obs   = 0;
        last_peak = -1;
    endtask

    task automatic pulseSeg(input int len, input int amp);
        for (int i = 0; i < len; i++) applyStimulus(1'b1, (i == len / 2) ? amp : amp / 2);
    endtask

    task automatic lowSeg(input int len);
        for (int i = 0; i < len; i++) applyStimulus(1'b0, NOISE);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " peak_out"}, 32'(peak_out), 0);
        checkOutput({tag, " peak_valid"}, 32'(peak_valid), 0);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " reject"}, 32'(reject), 0);
        checkOutput({tag, " rej_cnt"}, 32'(rej_cnt), 0);
    endtask

    // Reference model state: pulse samples are collected and judged when the pulse ends.
    int               m_mode;
    logic [ADC_W-1:0] m_samples[$];
    int               m_dead_left;
    logic             m_c1, m_cs, m_prev;
    logic [ADC_W-1:0] m_a1, m_ad;
    logic             m_vld, m_rej;
    logic [ADC_W-1:0] m_pout;
    int               m_cnt;

    task automatic modelReset();
        m_mode = 0; m_samples.delete(); m_dead_left = 0;
        m_c1 = 0; m_cs = 0; m_prev = 0; m_a1 = '0; m_ad = '0;
        m_vld = 0; m_rej = 0; m_pout = '0; m_cnt = 0;
    endtask

    function automatic logic [ADC_W-1:0] maxOf();
        logic [ADC_W-1:0] mx = '0;
        foreach (m_samples[i]) if (m_samples[i] > mx) mx = m_samples[i];
        return mx;
    endfunction

    // One clock of the model; c/a/r are the inputs present at the coming edge.
    task automatic modelStep(input logic c, input logic [ADC_W-1:0] a, input logic r);
        logic nrej;
        logic consumed;
        if (m_rej && m_cnt < 65535) m_cnt++;
        nrej     = 1'b0;
        consumed = m_vld && r;
        if (consumed) m_vld = 1'b0;
        if (m_mode == 0) begin
            if (m_cs) begin
                m_mode = 1;
                m_samples.delete();
                m_samples.push_back(m_ad);
            end
        end else if (m_mode == 1) begin
            if (m_cs && m_samples.size() < MAX_W) begin
                m_samples.push_back(m_ad);
            end else begin
                if (m_cs) nrej = 1'b1;
                else if (m_samples.size() < MIN_W) nrej = 1'b1;
                else if (m_vld) nrej = 1'b1;
                else begin
                    m_pout = maxOf();
                    m_vld  = 1'b1;
                end
                m_mode      = 2;
                m_dead_left = DEAD_T;
            end
        end else begin
            if (m_cs && !m_prev) nrej = 1'b1;
            if (m_dead_left == 1 && !m_cs) m_mode = 0;
            else if (m_dead_left > 1) m_dead_left--;
        end
        m_prev = m_cs;
        m_rej  = nrej;
        m_cs   = m_c1;
        m_c1   = c;
        m_ad   = m_a1;
        m_a1   = a;
    endtask

    initial begin
        vecs[0] = '{10, 1, 1, 1, 0};
        vecs[1] = '{1, 5, 0, 0, 1};
        vecs[2] = '{2, 6, 1, 6, 0};
        vecs[3] = '{64, 100, 1, 100, 0};
        vecs[4] = '{65, 100, 0, 0, 1};
        vecs[5] = '{80, 200, 0, 0, 1};
        vecs[6] = '{3, 1000, 1, 1000, 0};

        // Reset state
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst_n      = 1'b1;
        peak_ready = 1'b1;
        lowSeg(4);

        // Vector table: single pulses from idle
        foreach (vecs[k]) begin
            clearObs();
            pulseSeg(vecs[k].len, vecs[k].amp);
            lowSeg(14);
            exp_rej_total += vecs[k].exp_rej;
            checkOutput($sformatf("vec%0d events", k), ev_cnt, vecs[k].exp_events);
            if (vecs[k].exp_events > 0)
                checkOutput($sformatf("vec%0d peak", k), last_peak, vecs[k].exp_peak);
            checkOutput($sformatf("vec%0d rejects", k), rej_obs, vecs[k].exp_rej);
            checkOutput($sformatf("vec%0d rej_cnt", k), 32'(rej_cnt), expCnt(exp_rej_total));
            checkOutput($sformatf("vec%0d busy", k), 32'(busy), 0);
        end

        // Ramp 3,7,12,5 and output latency after the comparator falls
        clearObs();
        applyStimulus(1'b1, 3);
        applyStimulus(1'b1, 7);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b1, 5);
        applyStimulus(1'b0, NOISE);
        checkOutput("ramp lat1 valid", 32'(peak_valid), 0);
        applyStimulus(1'b0, NOISE);
        checkOutput("ramp lat2 valid", 32'(peak_valid), 0);
        applyStimulus(1'b0, NOISE);
        checkOutput("ramp lat3 valid", 32'(peak_valid), 1);
        checkOutput("ramp peak", 32'(peak_out), 12);
        applyStimulus(1'b0, NOISE);
        checkOutput("ramp valid cleared", 32'(peak_valid), 0);
        lowSeg(10);

        // Occupied output slot: second event rejected, first held
        peak_ready = 1'b0;
        clearObs();
        pulseSeg(3, 4);
        lowSeg(14);
        checkOutput("ovf first rejects", rej_obs, 0);
        clearObs();
        pulseSeg(3, 9);
        lowSeg(14);
        exp_rej_total += 1;
        checkOutput("ovf valid held", 32'(peak_valid), 1);
        checkOutput("ovf peak held", 32'(peak_out), 4);
        checkOutput("ovf rejects", rej_obs, 1);
        checkOutput("ovf rej_cnt", 32'(rej_cnt), expCnt(exp_rej_total));
        peak_ready = 1'b1;
        tick();
        checkOutput("ovf valid cleared", 32'(peak_valid), 0);
        lowSeg(4);

        // Pile-up: second pulse starts two cycles after the first ends
        clearObs();
        pulseSeg(3, 50);
        lowSeg(2);
        pulseSeg(3, 60);
        lowSeg(14);
        exp_rej_total += 1;
        checkOutput("pileup events", ev_cnt, 1);
        checkOutput("pileup peak", last_peak, 50);
        checkOutput("pileup rejects", rej_obs, 1);
        checkOutput("pileup rej_cnt", 32'(rej_cnt), expCnt(exp_rej_total));
        checkOutput("pileup busy", 32'(busy), 0);

        // Reset mid-pulse, comparator still high when reset releases
        clearObs();
        pulseSeg(8, 77);
        comparator = 1'b1;
        adc_in     = ADC_W'(33);
        rst_n      = 1'b0;
        #1;
        checkIdleOutputs("midreset");
        exp_rej_total = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clearObs();
        pulseSeg(5, 33);
        lowSeg(14);
        checkOutput("midreset events", ev_cnt, 1);
        checkOutput("midreset peak", last_peak, 33);
        checkOutput("midreset rejects", rej_obs, 0);
        checkOutput("midreset rej_cnt", 32'(rej_cnt), 0);

        // Randomized traffic against the reference model
        rst_n      = 1'b0;
        comparator = 1'b0;
        peak_ready = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        rst_n = 1'b1;
        begin
            int   seg_left = 0;
            logic level = 1'b0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                if (seg_left == 0) begin
                    level = !level;
                    if (level)
                        seg_left = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 8);
                    else
                        seg_left = $urandom_range(1, 8);
                end
                seg_left--;
                comparator = level;
                adc_in     = ADC_W'($urandom_range(0, NOISE));
                if (((cyc / 200) % 2) == 1) peak_ready = ($urandom_range(0, 7) == 0);
                else peak_ready = ($urandom_range(0, 3) != 0);
                modelStep(comparator, adc_in, peak_ready);
                @(negedge clk);
                checkOutput($sformatf("rnd%0d peak_valid", cyc), 32'(peak_valid), 32'(m_vld));
                checkOutput($sformatf("rnd%0d peak_out", cyc), 32'(peak_out), 32'(m_pout));
                checkOutput($sformatf("rnd%0d reject", cyc), 32'(reject), 32'(m_rej));
                checkOutput($sformatf("rnd%0d busy", cyc), 32'(busy), 32'(m_mode != 0));
                checkOutput($sformatf("rnd%0d rej_cnt", cyc), 32'(rej_cnt), expCnt(m_cnt));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
